// File: rtl/vga_glyph_row_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// vga_glyph_pkg
// Shared constants, slot-select helpers and the scheduler state encoding for
// the multi-glyph VGA row fetch path.
// -----------------------------------------------------------------------------
package vga_glyph_pkg;

  // Glyph geometry: each scan line of a glyph is three 16-bit ROM words.
  localparam int GLYPH_H       = 16;
  localparam int WORDS_PER_ROW = 3;
  localparam int WORD_W        = 16;
  localparam int ROW_BITS      = WORDS_PER_ROW * WORD_W;  // 48

  // Screen coordinates and ROM word addresses are both 10 bits wide.
  localparam int COORD_W = 10;
  localparam int ADDR_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    READY
  } state_e;

  // LSB of glyph g's field inside a packed {y|base} vector.
  function automatic int coord_lsb(input int g);
    return g * COORD_W;
  endfunction

  // MSB of word k of glyph g inside a packed row vector; word 0 is the MSBs.
  function automatic int word_msb(input int g, input int k);
    return g * ROW_BITS + ROW_BITS - 1 - k * WORD_W;
  endfunction

endpackage

// File: rtl/vga_glyph_row_scheduler.sv
// -----------------------------------------------------------------------------
// vga_glyph_row_scheduler
// During horizontal blanking, fetches the next scan line's 48-bit row of every
// glyph slot from one shared glyph word ROM, then commits all rows at once at
// the start of that line.
//
// Ports
//   pixelClock  pixel clock
//   reset       synchronous, active-low
//   hcount      horizontal pixel counter
//   vcount      vertical line counter
//   yFlat       top-line position per glyph, 10 bits each
//   baseFlat    ROM base word address per glyph, 10 bits each
//   bram_q      ROM read data, valid one cycle after bram_addr/bram_en
//   bram_addr   ROM word address
//   bram_en     ROM read strobe
//   dataInFlat  committed rows, 48 bits per glyph
//   rowsCommit  one-cycle pulse when dataInFlat updates
//   busy        high while fetching (ISSUE or DRAIN)
//   overrun     sticky: a line started before the fetch finished
// -----------------------------------------------------------------------------
module vga_glyph_row_scheduler
  import vga_glyph_pkg::*;
#(
  parameter int NUM_GLYPHS = 5,
  parameter int GLYPH_H    = vga_glyph_pkg::GLYPH_H,
  parameter int H_TRIGGER  = 640,
  parameter int V_TOTAL    = 525
) (
  input  logic                           pixelClock,
  input  logic                           reset,
  input  logic [COORD_W-1:0]             hcount,
  input  logic [COORD_W-1:0]             vcount,
  input  logic [NUM_GLYPHS*COORD_W-1:0]  yFlat,
  input  logic [NUM_GLYPHS*COORD_W-1:0]  baseFlat,
  input  logic [WORD_W-1:0]              bram_q,
  output logic [ADDR_W-1:0]              bram_addr,
  output logic                           bram_en,
  output logic [NUM_GLYPHS*ROW_BITS-1:0] dataInFlat,
  output logic                           rowsCommit,
  output logic                           busy,
  output logic                           overrun
);

  localparam int G_W   = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
  localparam int ROW_W = $clog2(GLYPH_H);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                        state_q,     state_d;
  logic [G_W-1:0]                g_q,         g_d;         // glyph on the bus
  logic [1:0]                    k_q,         k_d;         // word on the bus
  logic [COORD_W-1:0]            next_v_q,    next_v_d;
  logic [NUM_GLYPHS*COORD_W-1:0] y_snap_q,    y_snap_d;
  logic [NUM_GLYPHS*COORD_W-1:0] base_snap_q, base_snap_d;
  logic [ADDR_W-1:0]             bram_addr_q, bram_addr_d;
  logic                          bram_en_q,   bram_en_d;
  // Capture stage: describes the word whose ROM data is on bram_q this cycle.
  logic                          cap_valid_q, cap_valid_d;
  logic [G_W-1:0]                cap_g_q,     cap_g_d;
  logic [1:0]                    cap_k_q,     cap_k_d;
  logic                          cap_hit_q,   cap_hit_d;
  logic [NUM_GLYPHS*ROW_BITS-1:0] shadow_q,   shadow_d;
  logic [NUM_GLYPHS*ROW_BITS-1:0] data_q,     data_d;
  logic                          commit_q,    commit_d;
  logic                          busy_q,      busy_d;
  logic                          overrun_q,   overrun_d;

  // ---------------------------------------------------------------------------
  // Line events
  // ---------------------------------------------------------------------------
  logic               trigger;
  logic               line_start;
  logic               abort;
  logic               commit;
  logic               last_step;
  logic [COORD_W-1:0] next_v_live;

  // A trigger mid-fetch is ignored; in READY it discards the pending rows and
  // starts over for the new line.
  assign trigger     = (hcount == COORD_W'(H_TRIGGER)) &&
                       ((state_q == IDLE) || (state_q == READY));
  assign line_start  = (hcount == '0);
  assign abort       = line_start && ((state_q == ISSUE) || (state_q == DRAIN));
  assign commit      = line_start && (state_q == READY);
  assign last_step   = (g_q == G_W'(NUM_GLYPHS - 1)) &&
                       (k_q == 2'(WORDS_PER_ROW - 1));
  assign next_v_live = (vcount == COORD_W'(V_TOTAL - 1)) ? '0
                                                         : vcount + COORD_W'(1);

  // ---------------------------------------------------------------------------
  // Fetch address generation (one word per cycle)
  // ---------------------------------------------------------------------------
  logic               do_fetch;
  logic               fetch_live;   // first word: use live inputs, snapshot not yet loaded
  logic [G_W-1:0]     fetch_g;
  logic [1:0]         fetch_k;
  logic [COORD_W-1:0] fetch_v;
  logic [COORD_W-1:0] fetch_y;
  logic [ADDR_W-1:0]  fetch_base;
  logic               fetch_hit;
  logic [ROW_W-1:0]   fetch_row;
  logic [ADDR_W-1:0]  fetch_addr;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    state_d     = state_q;
    g_d         = g_q;
    k_d         = k_q;
    next_v_d    = next_v_q;
    y_snap_d    = y_snap_q;
    base_snap_d = base_snap_q;
    bram_addr_d = bram_addr_q;   // address holds across misses and idle
    bram_en_d   = 1'b0;
    cap_valid_d = 1'b0;
    cap_g_d     = cap_g_q;
    cap_k_d     = cap_k_q;
    cap_hit_d   = cap_hit_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    commit_d    = 1'b0;
    overrun_d   = overrun_q;
    do_fetch    = 1'b0;
    fetch_live  = 1'b0;
    fetch_g     = '0;
    fetch_k     = '0;
    fetch_v     = next_v_q;
    fetch_y     = '0;
    fetch_base  = '0;
    fetch_hit   = 1'b0;
    fetch_row   = '0;
    fetch_addr  = '0;

    // Land the word issued last cycle; a missed glyph's slot is cleared.
    if (cap_valid_q) begin
      shadow_d[word_msb(int'(cap_g_q), int'(cap_k_q)) -: WORD_W] =
        cap_hit_q ? bram_q : '0;
    end

    if (abort) begin
      state_d   = IDLE;
      data_d    = '0;
      overrun_d = 1'b1;
    end else if (commit) begin
      state_d  = IDLE;
      data_d   = shadow_q;
      commit_d = 1'b1;
    end else if (trigger) begin
      state_d     = ISSUE;
      g_d         = '0;
      k_d         = '0;
      next_v_d    = next_v_live;
      y_snap_d    = yFlat;
      base_snap_d = baseFlat;
      do_fetch    = 1'b1;
      fetch_live  = 1'b1;
      fetch_v     = next_v_live;
    end else if (state_q == ISSUE) begin
      cap_valid_d = 1'b1;
      cap_g_d     = g_q;
      cap_k_d     = k_q;
      cap_hit_d   = bram_en_q;
      if (last_step) begin
        state_d = DRAIN;
      end else begin
        if (k_q == 2'(WORDS_PER_ROW - 1)) begin
          g_d = g_q + G_W'(1);
          k_d = '0;
        end else begin
          k_d = k_q + 2'd1;
        end
        do_fetch = 1'b1;
        fetch_g  = g_d;
        fetch_k  = k_d;
      end
    end else if (state_q == DRAIN) begin
      state_d = READY;
    end

    if (do_fetch) begin
      fetch_y    = fetch_live ? yFlat[coord_lsb(int'(fetch_g)) +: COORD_W]
                              : y_snap_q[coord_lsb(int'(fetch_g)) +: COORD_W];
      fetch_base = fetch_live ? baseFlat[coord_lsb(int'(fetch_g)) +: COORD_W]
                              : base_snap_q[coord_lsb(int'(fetch_g)) +: COORD_W];
      // 11-bit compare so y near the bottom of the range cannot wrap.
      fetch_hit  = ({1'b0, fetch_v} >= {1'b0, fetch_y}) &&
                   ({1'b0, fetch_v} <  ({1'b0, fetch_y} + 11'(GLYPH_H)));
      fetch_row  = ROW_W'(fetch_v - fetch_y);
      fetch_addr = fetch_base + ADDR_W'(WORDS_PER_ROW * int'(fetch_row)) +
                   ADDR_W'(fetch_k);
      bram_en_d  = fetch_hit;
      if (fetch_hit) begin
        bram_addr_d = fetch_addr;
      end
    end

    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge pixelClock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (!reset) begin
      // NOTE: the shadow row store is a handful of flops, not a RAM, so it is
      // reset with everything else; a mid-fetch reset leaves nothing to commit.
      state_q     <= IDLE;
      g_q         <= '0;
      k_q         <= '0;
      next_v_q    <= '0;
      y_snap_q    <= '0;
      base_snap_q <= '0;
      bram_addr_q <= '0;
      bram_en_q   <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_g_q     <= '0;
      cap_k_q     <= '0;
      cap_hit_q   <= 1'b0;
      shadow_q    <= '0;
      data_q      <= '0;
      commit_q    <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      k_q         <= k_d;
      next_v_q    <= next_v_d;
      y_snap_q    <= y_snap_d;
      base_snap_q <= base_snap_d;
      bram_addr_q <= bram_addr_d;
      bram_en_q   <= bram_en_d;
      cap_valid_q <= cap_valid_d;
      cap_g_q     <= cap_g_d;
      cap_k_q     <= cap_k_d;
      cap_hit_q   <= cap_hit_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      commit_q    <= commit_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bram_addr  = bram_addr_q;
  assign bram_en    = bram_en_q;
  assign dataInFlat = data_q;
  assign rowsCommit = commit_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_vga_glyph_row_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_glyph_row_scheduler
// Directed bench for vga_glyph_row_scheduler with a behavioural one-cycle
// glyph word ROM.
// -----------------------------------------------------------------------------
module tb_vga_glyph_row_scheduler;

  localparam int N = 5;

  logic             pixelClock = 1'b0;
  logic             reset;
  logic [9:0]       hcount;
  logic [9:0]       vcount;
  logic [N*10-1:0]  yFlat;
  logic [N*10-1:0]  baseFlat;
  logic [15:0]      bram_q = 16'h0;
  logic [9:0]       bram_addr;
  logic             bram_en;
  logic [N*48-1:0]  dataInFlat;
  logic             rowsCommit;
  logic             busy;
  logic             overrun;

  int total = 0;
  int bad   = 0;

  logic             en_log   [15];
  logic [9:0]       addr_log [15];
  logic [N*48-1:0]  exp_d;

  vga_glyph_row_scheduler #(
    .NUM_GLYPHS(N),
    .GLYPH_H   (16),
    .H_TRIGGER (640),
    .V_TOTAL   (525)
  ) dut (
    .pixelClock(pixelClock),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .yFlat     (yFlat),
    .baseFlat  (baseFlat),
    .bram_q    (bram_q),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .dataInFlat(dataInFlat),
    .rowsCommit(rowsCommit),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 pixelClock = ~pixelClock;

  // ROM contents: never zero, distinct per address.
  function automatic logic [15:0] rom_word(input logic [9:0] a);
    return 16'hA5A5 ^ {a[5:0], a};
  endfunction

  function automatic logic [47:0] row_of(input logic [9:0] a);
    return {rom_word(a), rom_word(a + 10'd1), rom_word(a + 10'd2)};
  endfunction

  always @(posedge pixelClock) begin
    if (bram_en) bram_q <= rom_word(bram_addr);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge pixelClock);
    #1;
  endtask

  task automatic set_all_y(input logic [9:0] y);
    for (int g = 0; g < N; g++) begin
      yFlat[g*10 +: 10]    = y;
      baseFlat[g*10 +: 10] = 10'd0;
    end
  endtask

  task automatic set_glyph(input int g, input logic [9:0] y, input logic [9:0] b);
    yFlat[g*10 +: 10]    = y;
    baseFlat[g*10 +: 10] = b;
  endtask

  // Presents the trigger at the next edge; returns just after it with word 0 on the bus.
  task automatic do_trigger(input logic [9:0] v);
    hcount = 10'd640;
    vcount = v;
    tick();
    hcount = 10'd641;
  endtask

  // Logs the 15 issued words (starting right after the trigger edge).
  task automatic collect_steps();
    en_log[0]   = bram_en;
    addr_log[0] = bram_addr;
    for (int s = 1; s < 15; s++) begin
      tick();
      en_log[s]   = bram_en;
      addr_log[s] = bram_addr;
    end
  endtask

  // From the last issued word: DRAIN, READY, then the hcount==0 commit edge.
  task automatic drain_and_commit();
    tick();
    tick();
    hcount = 10'd0;
    tick();
    hcount = 10'd641;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    hcount = 10'd641;
    vcount = 10'd0;
    set_all_y(10'd400);
    tick();
    tick();
    total++; if (bram_addr !== 10'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", bram_addr); end
    total++; if (bram_en !== 1'b0) begin bad++; $display("FAIL reset_en: got %0b want 0", bram_en); end
    total++; if (dataInFlat !== '0) begin bad++; $display("FAIL reset_data: got %0h want 0", dataInFlat); end
    total++; if (rowsCommit !== 1'b0) begin bad++; $display("FAIL reset_commit: got %0b want 0", rowsCommit); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_hit();
    logic [9:0] exp_a;
    set_all_y(10'd400);
    set_glyph(0, 10'd10, 10'd0);
    do_trigger(10'd9);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_issue: got %0b want 1", busy); end
    collect_steps();
    for (int s = 0; s < 15; s++) begin
      exp_a = (s < 3) ? 10'(s) : 10'd2;
      total++; if (en_log[s] !== 1'(s < 3)) begin bad++; $display("FAIL single_en[%0d]: got %0b want %0b", s, en_log[s], s < 3); end
      total++; if (addr_log[s] !== exp_a) begin bad++; $display("FAIL single_addr[%0d]: got %0d want %0d", s, addr_log[s], exp_a); end
    end
    tick();  // DRAIN
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_drain: got %0b want 1", busy); end
    total++; if (bram_en !== 1'b0) begin bad++; $display("FAIL single_en_drain: got %0b want 0", bram_en); end
    tick();  // READY
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_ready: got %0b want 0", busy); end
    total++; if (rowsCommit !== 1'b0) begin bad++; $display("FAIL single_early_commit: got %0b want 0", rowsCommit); end
    hcount = 10'd0;
    tick();
    hcount = 10'd641;
    exp_d = '0;
    exp_d[47:0] = row_of(10'd0);
    total++; if (rowsCommit !== 1'b1) begin bad++; $display("FAIL single_commit: got %0b want 1", rowsCommit); end
    total++; if (dataInFlat !== exp_d) begin bad++; $display("FAIL single_data: got %0h want %0h", dataInFlat, exp_d); end
    tick();
    total++; if (rowsCommit !== 1'b0) begin bad++; $display("FAIL single_commit_pulse: got %0b want 0", rowsCommit); end
  endtask

  task automatic test_row_base();
    set_all_y(10'd400);
    set_glyph(1, 10'd130, 10'd48);
    do_trigger(10'd140);  // nextV=141, r=11 -> 48+33=81
    collect_steps();
    for (int s = 0; s < 15; s++) begin
      total++; if (en_log[s] !== 1'(s >= 3 && s < 6)) begin bad++; $display("FAIL rowbase_en[%0d]: got %0b", s, en_log[s]); end
      if (s >= 3 && s < 6) begin
        total++; if (addr_log[s] !== 10'(78 + s)) begin bad++; $display("FAIL rowbase_addr[%0d]: got %0d want %0d", s, addr_log[s], 78 + s); end
      end
    end
    drain_and_commit();
    exp_d = '0;
    exp_d[95:48] = row_of(10'd81);
    total++; if (dataInFlat !== exp_d) begin bad++; $display("FAIL rowbase_data: got %0h want %0h", dataInFlat, exp_d); end
  endtask

  task automatic test_frame_wrap();
    set_all_y(10'd400);
    set_glyph(0, 10'd0, 10'd200);
    set_glyph(1, 10'd520, 10'd5);
    do_trigger(10'd524);  // nextV wraps to 0
    collect_steps();
    for (int s = 0; s < 6; s++) begin
      total++; if (en_log[s] !== 1'(s < 3)) begin bad++; $display("FAIL wrap_en[%0d]: got %0b", s, en_log[s]); end
      if (s < 3) begin
        total++; if (addr_log[s] !== 10'(200 + s)) begin bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", s, addr_log[s], 200 + s); end
      end
    end
    drain_and_commit();
    exp_d = '0;
    exp_d[47:0] = row_of(10'd200);
    total++; if (dataInFlat !== exp_d) begin bad++; $display("FAIL wrap_data: got %0h want %0h", dataInFlat, exp_d); end
  endtask

  task automatic test_boundary();
    set_all_y(10'd400);
    set_glyph(2, 10'd50, 10'd100);
    // nextV=66 is one past the last line: miss, slot 2 cleared.
    do_trigger(10'd65);
    collect_steps();
    for (int s = 0; s < 15; s++) begin
      total++; if (en_log[s] !== 1'b0) begin bad++; $display("FAIL bound_miss_en[%0d]: got %0b want 0", s, en_log[s]); end
    end
    drain_and_commit();
    total++; if (rowsCommit !== 1'b1) begin bad++; $display("FAIL bound_miss_commit: got %0b want 1", rowsCommit); end
    total++; if (dataInFlat !== '0) begin bad++; $display("FAIL bound_miss_data: got %0h want 0", dataInFlat); end
    // nextV=65 is the last line: r=15 -> 100+45=145.
    do_trigger(10'd64);
    collect_steps();
    for (int s = 6; s < 9; s++) begin
      total++; if (en_log[s] !== 1'b1) begin bad++; $display("FAIL bound_hit_en[%0d]: got %0b want 1", s, en_log[s]); end
      total++; if (addr_log[s] !== 10'(139 + s)) begin bad++; $display("FAIL bound_hit_addr[%0d]: got %0d want %0d", s, addr_log[s], 139 + s); end
    end
    drain_and_commit();
    exp_d = '0;
    exp_d[143:96] = row_of(10'd145);
    total++; if (dataInFlat !== exp_d) begin bad++; $display("FAIL bound_hit_data: got %0h want %0h", dataInFlat, exp_d); end
  endtask

  task automatic test_overrun();
    int pulses;
    set_all_y(10'd400);
    set_glyph(0, 10'd10, 10'd0);
    do_trigger(10'd9);          // just after edge T
    repeat (4) tick();          // just after edge T+4
    hcount = 10'd0;
    tick();                     // edge T+5 sees hcount==0 in ISSUE
    hcount = 10'd641;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %0b want 1", overrun); end
    total++; if (dataInFlat !== '0) begin bad++; $display("FAIL ovr_data: got %0h want 0", dataInFlat); end
    total++; if (rowsCommit !== 1'b0) begin bad++; $display("FAIL ovr_commit: got %0b want 0", rowsCommit); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_busy: got %0b want 0", busy); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      hcount = (i == 10) ? 10'd0 : 10'd641;  // a line start while IDLE
      tick();
      if (rowsCommit === 1'b1 || busy === 1'b1) pulses++;
    end
    hcount = 10'd641;
    total++; if (pulses !== 0) begin bad++; $display("FAIL ovr_idle_activity: got %0d want 0", pulses); end
    total++; if (dataInFlat !== '0) begin bad++; $display("FAIL ovr_idle_data: got %0h want 0", dataInFlat); end
    // A normal line afterwards still commits; overrun stays set.
    do_trigger(10'd9);
    collect_steps();
    drain_and_commit();
    exp_d = '0;
    exp_d[47:0] = row_of(10'd0);
    total++; if (rowsCommit !== 1'b1) begin bad++; $display("FAIL ovr_next_commit: got %0b want 1", rowsCommit); end
    total++; if (dataInFlat !== exp_d) begin bad++; $display("FAIL ovr_next_data: got %0h want %0h", dataInFlat, exp_d); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
    // hcount==0 in IDLE: data holds, no pulse.
    hcount = 10'd0;
    tick();
    hcount = 10'd641;
    total++; if (rowsCommit !== 1'b0) begin bad++; $display("FAIL idle_line_commit: got %0b want 0", rowsCommit); end
    total++; if (dataInFlat !== exp_d) begin bad++; $display("FAIL idle_line_data: got %0h want %0h", dataInFlat, exp_d); end
  endtask

  task automatic test_reset_mid_fetch();
    set_all_y(10'd400);
    set_glyph(0, 10'd10, 10'd0);
    do_trigger(10'd9);
    repeat (7) tick();          // just after edge T+7
    reset = 1'b0;
    tick();                     // edge T+8
    reset = 1'b1;
    total++; if (bram_addr !== 10'd0) begin bad++; $display("FAIL rstmid_addr: got %0d want 0", bram_addr); end
    total++; if (bram_en !== 1'b0) begin bad++; $display("FAIL rstmid_en: got %0b want 0", bram_en); end
    total++; if (dataInFlat !== '0) begin bad++; $display("FAIL rstmid_data: got %0h want 0", dataInFlat); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rstmid_overrun: got %0b want 0", overrun); end
    repeat (20) tick();
    hcount = 10'd0;
    tick();
    hcount = 10'd641;
    total++; if (rowsCommit !== 1'b0) begin bad++; $display("FAIL rstmid_commit: got %0b want 0", rowsCommit); end
    total++; if (dataInFlat !== '0) begin bad++; $display("FAIL rstmid_data_after: got %0h want 0", dataInFlat); end
  endtask

  task automatic test_back_to_back();
    set_all_y(10'd400);
    set_glyph(0, 10'd10, 10'd0);
    set_glyph(4, 10'd300, 10'd500);
    // Fetch A: a trigger mid-ISSUE and input changes must not disturb it.
    do_trigger(10'd9);
    repeat (3) tick();
    hcount = 10'd640;
    vcount = 10'd299;
    yFlat[9:0] = 10'd400;
    tick();
    hcount = 10'd641;
    repeat (12) tick();         // now in READY
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_ready_busy: got %0b want 0", busy); end
    hcount = 10'd0;
    tick();
    hcount = 10'd641;
    exp_d = '0;
    exp_d[47:0] = row_of(10'd0);
    total++; if (dataInFlat !== exp_d) begin bad++; $display("FAIL b2b_snapshot_data: got %0h want %0h", dataInFlat, exp_d); end
    // Fetch B reaches READY, then a trigger in READY restarts for line 300.
    yFlat[9:0] = 10'd10;
    do_trigger(10'd9);
    collect_steps();
    tick();
    tick();                     // READY, shadow holds fetch B
    yFlat[9:0] = 10'd400;
    do_trigger(10'd299);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy: got %0b want 1", busy); end
    collect_steps();
    for (int s = 12; s < 15; s++) begin
      total++; if (addr_log[s] !== 10'(488 + s)) begin bad++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", s, addr_log[s], 488 + s); end
    end
    drain_and_commit();
    exp_d = '0;
    exp_d[239:192] = row_of(10'd500);
    total++; if (rowsCommit !== 1'b1) begin bad++; $display("FAIL b2b_commit: got %0b want 1", rowsCommit); end
    total++; if (dataInFlat !== exp_d) begin bad++; $display("FAIL b2b_data: got %0h want %0h", dataInFlat, exp_d); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_row_base();
    test_frame_wrap();
    test_boundary();
    test_overrun();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule
